// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Data-memory sequencing states
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // A younger stage's write of rd is visible to a read of rs; x0 never matches.
  function automatic logic reg_match(input logic [4:0] rs,
                                     input logic [4:0] rd,
                                     input logic       we);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: dmem_req/dmem_ack handshake; controller freezes stages until ack.
// master: datapath side (drives stage info and dmem_ack, receives controls).
// slave : controller side (receives stage info, drives stall/flush/fwd/dmem_req).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_redirect;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic             mem_mem_op;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic             dmem_ack;
  logic             dmem_req;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic [1:0]       fwd_rs1_sel;
  logic [1:0]       fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_redirect,
    output mem_rd, mem_reg_write, mem_mem_op, wb_rd, wb_reg_write, dmem_ack,
    input  dmem_req, stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w, fwd_rs1_sel, fwd_rs2_sel,
    input  stall_cycles, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_redirect,
    input  mem_rd, mem_reg_write, mem_mem_op, wb_rd, wb_reg_write, dmem_ack,
    output dmem_req, stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w, fwd_rs1_sel, fwd_rs2_sel,
    output stall_cycles, mem_timeout
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// EX operand forwarding select for one source register (MEM beats WB beats regfile).
// Latency: combinational.
// Backpressure: none.
// Ports: rs (EX source), mem_rd/mem_reg_write, wb_rd/wb_reg_write -> sel.
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (reg_match(rs, mem_rd, mem_reg_write)) begin
      sel = FWD_MEM;
    end else if (reg_match(rs, wb_rd, wb_reg_write)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline plus dmem wait sequencing.
// Latency: controls are combinational from stage info; state/counters update each clk.
// Backpressure: dmem miss freezes IF..MEM and bubbles WB until dmem_ack.
// Ports: clk, rst (sync, active-high), hz (slave side of pipeline_hazard_ctrl_if).
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q;
  state_e             state_d;
  logic [WCNT_W-1:0]  wait_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic               mem_stall;
  logic               load_use;
  logic               stall_f, stall_d, stall_e, stall_m;
  logic               flush_d, flush_e, flush_w;
  logic [1:0]         sel1, sel2;

  // State register, wait counter, sticky timeout, stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_MEM_WAIT && !hz.dmem_ack) begin
        if (wait_q != WCNT_W'(TIMEOUT_CYCLES)) begin
          wait_q <= wait_q + 1'b1;
        end
        // Count reaches the limit at this edge -> flag becomes visible with it
        if (wait_q >= WCNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_q <= 1'b1;
        end
      end else begin
        wait_q <= '0;
      end
      if (stall_f) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic; the FSM keeps waiting past the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (hz.mem_mem_op && !hz.dmem_ack) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (hz.dmem_ack) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Miss cycle in RUN, or any un-acked MEM_WAIT cycle
  assign mem_stall = (hz.mem_mem_op || state_q == ST_MEM_WAIT) && !hz.dmem_ack;

  assign load_use = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                    ((hz.id_rs1_used && hz.id_rs1 == hz.ex_rd) ||
                     (hz.id_rs2_used && hz.id_rs2 == hz.ex_rd));

  // Output logic: memory stall > redirect > load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.ex_redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  fwd_select u_fwd_rs1 (
    .rs            (hz.ex_rs1),
    .mem_rd        (hz.mem_rd),
    .mem_reg_write (hz.mem_reg_write),
    .wb_rd         (hz.wb_rd),
    .wb_reg_write  (hz.wb_reg_write),
    .sel           (sel1)
  );

  fwd_select u_fwd_rs2 (
    .rs            (hz.ex_rs2),
    .mem_rd        (hz.mem_rd),
    .mem_reg_write (hz.mem_reg_write),
    .wb_rd         (hz.wb_rd),
    .wb_reg_write  (hz.wb_reg_write),
    .sel           (sel2)
  );

  assign hz.dmem_req     = !rst && hz.mem_mem_op;
  assign hz.stall_f      = stall_f;
  assign hz.stall_d      = stall_d;
  assign hz.stall_e      = stall_e;
  assign hz.stall_m      = stall_m;
  assign hz.flush_d      = flush_d;
  assign hz.flush_e      = flush_e;
  assign hz.flush_w      = flush_w;
  assign hz.fwd_rs1_sel  = rst ? FWD_REG : sel1;
  assign hz.fwd_rs2_sel  = rst ? FWD_REG : sel2;
  assign hz.stall_cycles = stall_cnt_q;
  assign hz.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the combinational
// controls plus hand-written sequences for dmem wait, timeout and reset.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_checks = 0;
  int n_errors = 0;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1100010;
  localparam logic [6:0] C_RDIR  = 7'b0000110;
  localparam logic [6:0] C_MSTL  = 7'b1111001;

  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic       u1, u2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ld, redir;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic [6:0] exp_ctrl;
    logic [1:0] exp_f1, exp_f2;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
            hz.flush_d, hz.flush_e, hz.flush_w};
  endfunction

  task automatic idle_inputs();
    hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_rs1_used = 0; hz.id_rs2_used = 0;
    hz.ex_rs1 = 0; hz.ex_rs2 = 0; hz.ex_rd = 0; hz.ex_is_load = 0; hz.ex_redirect = 0;
    hz.mem_rd = 0; hz.mem_reg_write = 0; hz.mem_mem_op = 0;
    hz.wb_rd = 0; hz.wb_reg_write = 0; hz.dmem_ack = 0;
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_cnt;

    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_IDLE, 2'b00, 2'b00};
    vecs[1]  = '{5'd5, 5'd6, 1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_LU,   2'b00, 2'b00};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_IDLE, 2'b00, 2'b00};
    vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_IDLE, 2'b00, 2'b00};
    vecs[4]  = '{5'd3, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_IDLE, 2'b00, 2'b00};
    vecs[5]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_LU,   2'b00, 2'b00};
    vecs[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_IDLE, 2'b00, 2'b00};
    vecs[7]  = '{5'd5, 5'd6, 1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, C_RDIR, 2'b00, 2'b00};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, C_RDIR, 2'b00, 2'b00};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, C_IDLE, 2'b01, 2'b00};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, C_IDLE, 2'b10, 2'b00};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, C_IDLE, 2'b00, 2'b00};
    vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 5'd9, 1'b1, C_IDLE, 2'b01, 2'b01};
    vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd12, 5'd0, 1'b0, 1'b0, 5'd12, 1'b0, 5'd9, 1'b1, C_IDLE, 2'b10, 2'b00};
    vecs[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd2, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 5'd7, 1'b0, C_IDLE, 2'b00, 2'b01};

    // Reset holds every control low even with stall-provoking inputs
    idle_inputs();
    rst = 1'b1;
    hz.mem_mem_op = 1; hz.ex_redirect = 1;
    hz.ex_is_load = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_rs1_used = 1;
    hz.ex_rs1 = 7; hz.mem_rd = 7; hz.mem_reg_write = 1;
    next_cycle();
    @(negedge clk);
    chk("rst_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("rst_dmem_req", 32'(hz.dmem_req), 0);
    chk("rst_fwd1", 32'(hz.fwd_rs1_sel), 0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_stall_cycles", hz.stall_cycles, 0);
    chk("rst_timeout", 32'(hz.mem_timeout), 0);
    next_cycle();

    // Vector table (RUN state, no memory op)
    exp_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      hz.id_rs1 = vecs[i].id_rs1; hz.id_rs2 = vecs[i].id_rs2;
      hz.id_rs1_used = vecs[i].u1; hz.id_rs2_used = vecs[i].u2;
      hz.ex_rs1 = vecs[i].ex_rs1; hz.ex_rs2 = vecs[i].ex_rs2; hz.ex_rd = vecs[i].ex_rd;
      hz.ex_is_load = vecs[i].ld; hz.ex_redirect = vecs[i].redir;
      hz.mem_rd = vecs[i].mem_rd; hz.mem_reg_write = vecs[i].mem_rw;
      hz.wb_rd = vecs[i].wb_rd; hz.wb_reg_write = vecs[i].wb_rw;
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
      chk($sformatf("vec%0d_fwd1", i), 32'(hz.fwd_rs1_sel), 32'(vecs[i].exp_f1));
      chk($sformatf("vec%0d_fwd2", i), 32'(hz.fwd_rs2_sel), 32'(vecs[i].exp_f2));
      chk($sformatf("vec%0d_req", i), 32'(hz.dmem_req), 0);
      if (vecs[i].exp_ctrl[6]) exp_cnt++;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("table_stall_cycles", hz.stall_cycles, exp_cnt);
    next_cycle();

    // Three-cycle memory wait, then ack
    do_reset();
    for (int i = 0; i < 3; i++) begin
      hz.mem_mem_op = 1; hz.dmem_ack = 0;
      @(negedge clk);
      chk($sformatf("mw_ctrl%0d", i), 32'(ctrl_now()), 32'(C_MSTL));
      chk($sformatf("mw_req%0d", i), 32'(hz.dmem_req), 1);
      next_cycle();
    end
    hz.dmem_ack = 1;
    @(negedge clk);
    chk("mw_ack_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("mw_ack_req", 32'(hz.dmem_req), 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("mw_after_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("mw_after_req", 32'(hz.dmem_req), 0);
    chk("mw_stall_cycles", hz.stall_cycles, 3);
    chk("mw_timeout", 32'(hz.mem_timeout), 0);
    next_cycle();

    // Zero-wait access: no stall, stays in RUN
    hz.mem_mem_op = 1; hz.dmem_ack = 1;
    @(negedge clk);
    chk("zw_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("zw_after_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    next_cycle();

    // Redirect held during a memory wait acts only in the ack cycle
    for (int i = 0; i < 2; i++) begin
      hz.mem_mem_op = 1; hz.ex_redirect = 1; hz.dmem_ack = 0;
      @(negedge clk);
      chk($sformatf("rw_ctrl%0d", i), 32'(ctrl_now()), 32'(C_MSTL));
      next_cycle();
    end
    hz.dmem_ack = 1;
    @(negedge clk);
    chk("rw_ack_ctrl", 32'(ctrl_now()), 32'(C_RDIR));
    next_cycle();
    idle_inputs();

    // Timeout: 1 RUN miss cycle + 5 MEM_WAIT cycles without ack
    do_reset();
    for (int i = 0; i < 6; i++) begin
      hz.mem_mem_op = 1; hz.dmem_ack = 0;
      @(negedge clk);
      chk($sformatf("to_flag%0d", i), 32'(hz.mem_timeout), (i >= 5) ? 1 : 0);
      chk($sformatf("to_ctrl%0d", i), 32'(ctrl_now()), 32'(C_MSTL));
      next_cycle();
    end
    hz.dmem_ack = 1;
    @(negedge clk);
    chk("to_ack_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("to_ack_flag", 32'(hz.mem_timeout), 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("to_after_flag", 32'(hz.mem_timeout), 1);
    chk("to_stall_cycles", hz.stall_cycles, 6);
    next_cycle();

    // Reset asserted mid-MEM_WAIT
    for (int i = 0; i < 2; i++) begin
      hz.mem_mem_op = 1; hz.dmem_ack = 0;
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("rmw_req", 32'(hz.dmem_req), 0);
    next_cycle();
    rst = 1'b0;
    hz.mem_mem_op = 0; hz.dmem_ack = 0;
    @(negedge clk);
    chk("rmw_run_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("rmw_run_req", 32'(hz.dmem_req), 0);
    chk("rmw_timeout", 32'(hz.mem_timeout), 0);
    chk("rmw_stall_cycles", hz.stall_cycles, 0);
    next_cycle();
    hz.mem_mem_op = 1;
    @(negedge clk);
    chk("rmw_req_follow", 32'(hz.dmem_req), 1);
    next_cycle();
    idle_inputs();
    hz.dmem_ack = 1;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Detects load-use interlocks and taken branch/jump redirects.
- Selects EX-stage operand forwarding.
- Sequences the variable-latency data-memory handshake, freezing the pipeline while an access is outstanding.
- Sits beside the datapath; drives every pipeline register's stall/flush enable.

Parameters:
TIMEOUT_CYCLES, 256, MEM_WAIT cycles before the sticky mem_timeout flag sets
CNT_W, 32, width of the stall_cycles performance counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous, active-high reset
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rs1  in  5  EX-stage source register 1 (forwarding)
ex_rs2  in  5  EX-stage source register 2 (forwarding)
ex_rd  in  5  EX destination
ex_is_load  in  1  EX holds a load
ex_redirect  in  1  EX branch taken, JAL or JALR resolved
mem_rd  in  5  MEM destination
mem_reg_write  in  1  MEM writes rd
mem_mem_op  in  1  MEM holds a load/store
wb_rd  in  5  WB destination
wb_reg_write  in  1  WB writes rd
dmem_ack  in  1  data memory completes access this cycle
dmem_req  out  1  data memory request
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
stall_e  out  1  hold ID/EX
stall_m  out  1  hold EX/MEM
flush_d  out  1  bubble IF/ID
flush_e  out  1  bubble ID/EX
flush_w  out  1  bubble MEM/WB
fwd_rs1_sel  out  2  EX operand 1 source
fwd_rs2_sel  out  2  EX operand 2 source
stall_cycles  out  CNT_W  cycles with stall_f=1
mem_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=RUN; stall_cycles=0; mem_timeout=0; wait counter=0. While rst=1, all stall/flush/dmem_req outputs are 0 and fwd selects are 0, regardless of inputs.
- State register states:
  - RUN: normal flow.
  - MEM_WAIT: access outstanding.
- dmem_req = mem_mem_op in both states. It stays high continuously in MEM_WAIT until the ack cycle.
- RUN with mem_mem_op=1 and dmem_ack=0: enter MEM_WAIT next cycle. mem_mem_op=1 with dmem_ack=1: zero-wait access; no stall; remain in RUN.
- Memory stall is combinational, in RUN (miss cycle) and in MEM_WAIT while dmem_ack=0:
  - stall_f = stall_d = stall_e = stall_m = 1.
  - flush_w = 1.
  - flush_d = flush_e = 0.
- MEM_WAIT with dmem_ack=1: no stall that cycle; next state RUN; wait counter clears.
- Wait counter increments each MEM_WAIT cycle and saturates. When it reaches TIMEOUT_CYCLES, mem_timeout sets and stays set until rst. The FSM keeps waiting.
- Load-use (no memory stall active): ex_is_load, ex_rd != 0, and (id_rs1_used and id_rs1 == ex_rd, or id_rs2_used and id_rs2 == ex_rd). Response: stall_f = stall_d = 1, flush_e = 1, for exactly one cycle. The load then moves to MEM and the condition clears.
- Redirect (no memory stall active): ex_redirect=1 gives flush_d = flush_e = 1, no stalls.
- Priority, highest first: memory stall > redirect > load-use.
  - Redirect coincident with load-use: redirect only (the ID instruction is discarded).
  - Redirect during a memory stall: suppressed. ex_redirect stays valid in the held EX stage and is acted on in the ack cycle.
- Forwarding, per operand, combinational:
  - MEM match (mem_reg_write, mem_rd != 0, mem_rd == ex_rsX) gives sel=2'b01.
  - Otherwise WB match under the same rules gives 2'b10.
  - Otherwise 2'b00 (register file).
  - Register x0 is never forwarded.
- stall_cycles increments on every cycle with stall_f=1. It wraps modulo 2^CNT_W.

Decomposition:
- Add to the shared Parameters.v include:
  - forward-select encodings FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - FSM encodings ST_RUN, ST_MEM_WAIT.
- Sub-module fwd_select (rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write -> sel), instantiated twice.

Test Plan:
- Load x5 in EX, ID add reads rs1=x5 -> one cycle stall_f=stall_d=flush_e=1; next cycle all 0; stall_cycles=1.
- Same with ex_rd=0 (x0 load) -> no stall.
- mem_mem_op=1, dmem_ack low 3 cycles then high -> dmem_req high 4 cycles; stalls+flush_w high 3 cycles; RUN after ack; stall_cycles=3.
- ex_redirect=1 coincident with load-use -> flush_d=flush_e=1, stall_f=0; ex_redirect during MEM_WAIT -> flushes only in ack cycle.
- ex_rs1=x7, mem_rd=x7 and wb_rd=x7 both writing -> fwd_rs1_sel=01; MEM write disabled -> 10; rs=x0 with matches -> 00.
- TIMEOUT_CYCLES=4, ack withheld 6 cycles -> mem_timeout rises after the 4th wait cycle, stays high after ack; rst asserted mid-MEM_WAIT -> next cycle state RUN, dmem_req follows mem_mem_op, mem_timeout=0, stall_cycles=0.
